// File: rtl/alu64bit_arbiter.sv
// alu64bit_arbiter: round-robin sequencer sharing one 64-bit ALU among NREQ requesters.
// Ports: clk, rst (async, active-high); req_valid/req_ready handshake with packed
//   req_a/req_b (64b each), req_cin, req_op (2b each); tagged response channel
//   rsp_valid/rsp_ready, rsp_id, rsp_s, rsp_cout; busy while an operation is in flight.

module alu64bit #(
  parameter int nand_tpd = 0,
  parameter int or_tpd   = 0,
  parameter int xnor_tpd = 0
) (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  input  logic [1:0]  op,
  output logic [63:0] s,
  output logic        cout
);
  // op: 00 xor, 01 add with carry, 10 and, 11 or.
  // Gate delays only shape the timing model; this datapath is zero-delay.
  logic [64:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {64'd0, cin};

  always_comb begin
    s    = '0;
    cout = 1'b0;
    case (op)
      2'b00: s = a ^ b;
      2'b01: {cout, s} = sum;
      2'b10: s = a & b;
      2'b11: s = a | b;
    endcase
  end

  if (nand_tpd < 0 || or_tpd < 0 || xnor_tpd < 0) begin : g_bad_tpd
    $error("alu64bit: gate delays must be non-negative");
  end
endmodule

module alu64bit_arbiter #(
  parameter int NREQ     = 4,
  parameter int ALU_WAIT = 1,
  parameter int nand_tpd = 0,
  parameter int or_tpd   = 0,
  parameter int xnor_tpd = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*64-1:0]      req_a,
  input  logic [NREQ*64-1:0]      req_b,
  input  logic [NREQ-1:0]         req_cin,
  input  logic [NREQ*2-1:0]       req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [63:0]             rsp_s,
  output logic                    rsp_cout,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] id_q, id_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   a_q, a_d;
  logic [63:0]   b_q, b_d;
  logic          cin_q, cin_d;
  logic [1:0]    op_q, op_d;
  logic [63:0]   s_q, s_d;
  logic          cout_q, cout_d;

  logic [IW-1:0] gnt_idx;
  logic          gnt_found;
  logic [63:0]   alu_s;
  logic          alu_cout;

  // Search downward so the lowest offset from rr_q is the last match kept.
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req_valid[IW'(j)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      op_q    <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      op_q    <= op_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    op_d    = op_q;
    s_d     = s_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d     = req_a[{gnt_idx, 6'd0} +: 64];
          b_d     = req_b[{gnt_idx, 6'd0} +: 64];
          cin_d   = req_cin[gnt_idx];
          op_d    = req_op[{gnt_idx, 1'b0} +: 2];
          id_d    = gnt_idx;
          rr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d   = 4'(ALU_WAIT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          s_d     = alu_s;
          cout_d  = alu_cout;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is suppressed while rst is held so no ready is seen during reset.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found && !rst) req_ready[gnt_idx] = 1'b1;
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
  end

  assign rsp_id   = id_q;
  assign rsp_s    = s_q;
  assign rsp_cout = cout_q;

  alu64bit #(
    .nand_tpd (nand_tpd),
    .or_tpd   (or_tpd),
    .xnor_tpd (xnor_tpd)
  ) u_alu (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .op   (op_q),
    .s    (alu_s),
    .cout (alu_cout)
  );

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("alu64bit_arbiter: NREQ must be 2..8");
  end
  if (ALU_WAIT < 0 || ALU_WAIT > 15) begin : g_bad_wait
    $error("alu64bit_arbiter: ALU_WAIT must be 0..15");
  end
endmodule

// File: doc/alu64bit_arbiter.md
Name: alu64bit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one alu64bit instance between NREQ requesters.
- Each requester presents a, b, cin and op with a valid/ready handshake.
- The arbiter grants one request at a time, holds the registered operands stable for a programmable number of settle cycles, then returns the s/cout result on a single tagged response channel.
- It sits between the issuing units and the shared 64-bit ALU, which it instantiates internally.

Parameters:
NREQ, 4, number of requesters (2..8)
ALU_WAIT, 1, extra settle cycles added after the first EXEC cycle so the gate-delay ALU output is stable before capture (0..15)
nand_tpd, 0, forwarded to alu64bit
or_tpd, 0, forwarded to alu64bit
xnor_tpd, 0, forwarded to alu64bit

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept (one-hot or zero)
req_a  in  NREQ*64  operand a, requester i at bits [64i+63:64i]
req_b  in  NREQ*64  operand b, same packing
req_cin  in  NREQ  carry-in per requester
req_op  in  NREQ*2  op per requester, bits [2i+1:2i]
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  $clog2(NREQ)  index of requester that owns the result
rsp_s  out  64  ALU result
rsp_cout  out  1  ALU carry-out
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, rr pointer=0, wait counter=0, operand registers=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_cout=0, busy=0. A reset mid-operation aborts the operation; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE arbitration:
  - If any req_valid is set, grant the first set bit searching from rr pointer upward with wrap.
  - req_ready[g]=1 combinationally in that cycle only; all other req_ready bits=0.
  - req_ready is always 0 outside IDLE.
- On the handshake edge:
  - Latch req_a/b/cin/op[g] into operand registers and store g as the id.
  - rr pointer <= (g+1) mod NREQ.
  - Wait counter <= ALU_WAIT.
  - Go to EXEC.
- EXEC:
  - ALU inputs are driven only from the operand registers, so they are stable for the whole operation.
  - Each cycle: if counter!=0, decrement it; else capture alu s/cout into rsp_s/rsp_cout, set rsp_valid=1 and go to RESP.
  - EXEC therefore lasts ALU_WAIT+1 cycles.
  - rsp_valid rises after handshake edge + ALU_WAIT+1 edges.
- RESP:
  - rsp_valid, rsp_id, rsp_s and rsp_cout are held constant until rsp_ready=1 at a rising edge.
  - On that edge rsp_valid <= 0 and state goes to IDLE.
  - No grant occurs in the same cycle as response acceptance.
  - Minimum issue interval is ALU_WAIT+3 cycles.
- Requester rules:
  - A requester must keep req_valid and its operands stable until it sees req_ready.
  - Dropping req_valid before grant is permitted; the request is then simply not granted.
- Outside an operation, operand registers and rsp_* keep their last values.
- The op encoding belongs to alu64bit and is passed through unmodified. 2'b00 = XOR.
- Fairness: with all requesters continuously valid, the grant order is 0,1,...,NREQ-1,0,...
- Any single requester waits at most NREQ-1 operations.

Test Plan:
1. Reset then single request, ALU_WAIT=1:
   - Stimulus: req0 with op=00, cin=0, a=64'h00000000_FFFFFFFF, b=64'h0000FFFF_0000FFFF.
   - Required: req_ready[0] pulses for one cycle, rsp_valid rises 2 edges later, rsp_s=64'h0000FFFF_FFFF0000, rsp_id=0.
2. Same operands with cin=1:
   - Required: rsp_s and rsp_cout equal a directly instantiated golden alu64bit driven with the same inputs.
   - Repeat for op=01, 10 and 11 on a=64'hFFFFFFFF_FFFFFFFF, b=64'h1.
3. All 4 requests asserted continuously with rsp_ready=1:
   - Required: grant order 0,1,2,3,0; rsp_id follows the same order.
   - Consecutive req_ready pulses are exactly ALU_WAIT+3 cycles apart.
4. Backpressure:
   - Stimulus: hold rsp_ready=0 for 10 cycles in RESP.
   - Required: rsp_* stable, busy=1, req_ready stays 0 despite pending requests.
   - After rsp_ready=1, the next grant follows 1 cycle after return to IDLE.
5. Asynchronous reset mid-EXEC:
   - Stimulus: assert rst between clock edges during EXEC.
   - Required: outputs clear immediately with no rsp_valid.
   - After release, the next grant starts at requester 0.
6. Edge parameters:
   - With ALU_WAIT=0, rsp_valid rises 1 edge after handshake.
   - With NREQ=2 and only req1 valid, req1 is granted repeatedly and rr pointer wraps to 0 after each grant.
